// File: rtl/trencadis_pwm_generator.sv
// Tick-driven PWM with shadowed period/duty and graceful stop.
// Define TRENCADIS_PWM_COMPLEMENTARY_EN to add the pwm_n_o output.
module trencadis_pwm_generator #(
  parameter int SIZE = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            tick_i,
  input  logic            en_i,
  input  logic [SIZE-1:0] period_i,
  input  logic [SIZE-1:0] duty_i,
  output logic            pwm_o,
  output logic            period_end_o,
  output logic            busy_o
`ifdef TRENCADIS_PWM_COMPLEMENTARY_EN
  ,output logic           pwm_n_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [SIZE-1:0] ONE = SIZE'(1);

  state_e          state_q, state_d;
  logic [SIZE-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0] period_q, period_d;
  logic [SIZE-1:0] duty_q, duty_d;
  logic            pwm_q, pwm_d;
  logic            pe_q, pe_d;
  logic            busy_q, busy_d;
  logic            wrap;

  assign wrap = tick_i && (cnt_q == period_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    duty_d   = duty_q;
    pwm_d    = pwm_q;
    pe_d     = 1'b0;
    busy_d   = busy_q;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        pwm_d  = 1'b0;
        busy_d = 1'b0;
        if (en_i) begin
          period_d = period_i;
          duty_d   = duty_i;
          pwm_d    = (duty_i != '0);
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN, DRAIN: begin
        if (tick_i) cnt_d = wrap ? '0 : cnt_q + ONE;
        pe_d = wrap;
        // A wrap while stopping (or on the cycle en drops) ends the run
        if (wrap && (state_q == DRAIN || !en_i)) begin
          state_d = IDLE;
          cnt_d   = '0;
          pwm_d   = 1'b0;
          busy_d  = 1'b0;
        end else begin
          if (wrap) begin
            period_d = period_i;
            duty_d   = duty_i;
          end
          state_d = en_i ? RUN : DRAIN;
          pwm_d   = (cnt_d < duty_d);
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pwm_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

`ifdef TRENCADIS_PWM_COMPLEMENTARY_EN
  logic pwm_n_q, pwm_n_d;
  assign pwm_n_d = busy_d && !pwm_d;
  assign pwm_n_o = pwm_n_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      duty_q   <= '0;
      pwm_q    <= 1'b0;
      pe_q     <= 1'b0;
      busy_q   <= 1'b0;
`ifdef TRENCADIS_PWM_COMPLEMENTARY_EN
      pwm_n_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      pwm_q    <= pwm_d;
      pe_q     <= pe_d;
      busy_q   <= busy_d;
`ifdef TRENCADIS_PWM_COMPLEMENTARY_EN
      pwm_n_q  <= pwm_n_d;
`endif
    end
  end

  assign pwm_o        = pwm_q;
  assign period_end_o = pe_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_trencadis_pwm_generator.sv
// Bench for trencadis_pwm_generator: directed waveform checks plus a
// randomized run against a tick-position reference model.
module tb_trencadis_pwm_generator;

  localparam int SIZE = 8;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            tick_i = 1'b0;
  logic            en_i = 1'b0;
  logic [SIZE-1:0] period_i = '0;
  logic [SIZE-1:0] duty_i = '0;
  logic            pwm_o;
  logic            period_end_o;
  logic            busy_o;
`ifdef TRENCADIS_PWM_COMPLEMENTARY_EN
  logic            pwm_n_o;
`endif

  trencadis_pwm_generator #(.SIZE(SIZE)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .tick_i      (tick_i),
    .en_i        (en_i),
    .period_i    (period_i),
    .duty_i      (duty_i),
    .pwm_o       (pwm_o),
    .period_end_o(period_end_o),
    .busy_o      (busy_o)
`ifdef TRENCADIS_PWM_COMPLEMENTARY_EN
    ,.pwm_n_o    (pwm_n_o)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: active flag, stopping flag, tick position inside the period
  bit m_act, m_stop, m_pwm, m_pe;
  int m_pos, m_per, m_dut;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit w;
    if (rst_i) begin
      m_act = 0; m_stop = 0; m_pwm = 0; m_pe = 0;
      m_pos = 0; m_per = 0; m_dut = 0;
    end else if (!m_act) begin
      m_pe = 0;
      if (en_i) begin
        m_act = 1; m_stop = 0; m_pos = 0;
        m_per = int'(period_i); m_dut = int'(duty_i);
        m_pwm = (m_pos < m_dut);
      end
    end else begin
      w = tick_i && (m_pos == m_per);
      m_pe = w;
      if (tick_i) m_pos = (m_pos + 1) % (m_per + 1);
      if (w && (m_stop || !en_i)) begin
        m_act = 0; m_stop = 0; m_pwm = 0; m_pos = 0;
      end else begin
        if (w) begin
          m_per = int'(period_i); m_dut = int'(duty_i);
        end
        m_stop = !en_i;
        m_pwm = (m_pos < m_dut);
      end
    end
  endtask

  task automatic compare();
    chk("pwm", int'(pwm_o), int'(m_pwm));
    chk("period_end", int'(period_end_o), int'(m_pe));
    chk("busy", int'(busy_o), int'(m_act));
`ifdef TRENCADIS_PWM_COMPLEMENTARY_EN
    chk("pwm_n", int'(pwm_n_o), int'(m_act && !m_pwm));
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  // Measurements of a directed run
  int hq[$];
  int gq[$];
  int th, npe, fall_k;
  bit pe_at_fall;
  int snap_pwm[2], snap_busy[2], snap_pe[2];

  task automatic run(input int n, input int per, input int da, input int db,
                     input int sw, input int drop, input int rise,
                     input int rst_at);
    int hc, gap;
    hq.delete(); gq.delete();
    th = 0; npe = 0; fall_k = -1; pe_at_fall = 0;
    hc = 0; gap = 0;
    for (int k = 0; k < n; k++) begin
      rst_i    = (k == rst_at);
      tick_i   = (k % 4 == 3);
      en_i     = !(k >= drop && k < rise);
      period_i = SIZE'(per);
      duty_i   = SIZE'(k < sw ? da : db);
      cyc();
      if (period_end_o) begin
        hq.push_back(hc); gq.push_back(gap);
        hc = int'(pwm_o); gap = 1; npe++;
      end else begin
        hc += int'(pwm_o); gap++;
      end
      th += int'(pwm_o);
      if (!busy_o && fall_k < 0 && rst_at < 0) begin
        fall_k = k; pe_at_fall = period_end_o;
      end
      if (k == rst_at || k == rst_at + 1) begin
        snap_pwm[k - rst_at]  = int'(pwm_o);
        snap_busy[k - rst_at] = int'(busy_o);
        snap_pe[k - rst_at]   = int'(period_end_o);
      end
    end
  endtask

  task automatic do_reset();
    rst_i = 1; en_i = 0; tick_i = 0;
    cyc(); cyc();
    rst_i = 0;
    cyc();
  endtask

  initial begin
    do_reset();
    chk("reset_pwm", int'(pwm_o), 0);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_pe", int'(period_end_o), 0);

    // Basic waveform: 3 high ticks of 10, tick every 4 clocks
    run(170, 9, 3, 3, 0, 1000, 1000, -1);
    chk("basic_high", hq[1], 12);
    chk("basic_gap", gq[1], 40);
    chk("basic_high2", hq[2], 12);
    chk("basic_gap2", gq[2], 40);

    do_reset();
    run(100, 9, 0, 0, 0, 1000, 1000, -1);
    chk("duty0_high", th, 0);

    do_reset();
    run(100, 9, 10, 10, 0, 1000, 1000, -1);
    chk("duty_full_high", th, 100);

    do_reset();
    run(100, 0, 1, 1, 0, 1000, 1000, -1);
    chk("per0_high", th, 100);
    chk("per0_pulses", npe, 25);

    // Duty changes 3 -> 7 at cnt=5: current period keeps 3
    do_reset();
    run(170, 9, 3, 7, 60, 1000, 1000, -1);
    chk("shadow_cur", hq[1], 12);
    chk("shadow_next", hq[2], 28);

    // Graceful stop: en drops at cnt=2, period completes
    do_reset();
    run(120, 9, 3, 3, 0, 48, 1000, -1);
    chk("stop_fall", fall_k, 79);
    chk("stop_pe", int'(pe_at_fall), 1);
    chk("stop_parked", int'(pwm_o), 0);

    // Re-assert at cnt=6: no restart, period still 40 clocks
    do_reset();
    run(120, 9, 3, 3, 0, 48, 64, -1);
    chk("resume_nofall", fall_k, -1);
    chk("resume_gap", gq[1], 40);

    // Reset mid-period at cnt=5 with pwm high, then restart
    do_reset();
    run(120, 9, 8, 8, 0, 1000, 1000, 60);
    chk("rst_pwm", snap_pwm[0], 0);
    chk("rst_busy", snap_busy[0], 0);
    chk("rst_pe", snap_pe[0], 0);
    chk("restart_pwm", snap_pwm[1], 1);
    chk("restart_busy", snap_busy[1], 1);

    // Randomized traffic
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      rst_i  = ($urandom_range(0, 199) == 0);
      tick_i = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 19) == 0) en_i = !en_i;
      if ($urandom_range(0, 9) == 0) period_i = SIZE'($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) duty_i = SIZE'($urandom_range(0, 7));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
